// File: rtl/ide_fifo_arbiter.sv
// ide_fifo_arbiter: shares the IDE PIO data bus between the read-data and
// write-data FIFO channels, one fixed-length burst at a time, with a guard
// gap after each burst.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   IDLE     | bus free, waiting for rd_ok / wr_ok
//   GRANT_RD | read channel owns the bus, counting word strobes
//   GRANT_WR | write channel owns the bus, counting word strobes
//   GUARD    | post-burst dead time, both grants low
module ide_fifo_arbiter #(
  parameter int          SECTOR_WORDS  = 256,
  parameter logic [12:0] RD_HIGH_WATER = 13'd3000,
  parameter int          GUARD_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        rd_req,
  input  logic [12:0] rd_fifo_usedw,
  input  logic        wr_req,
  input  logic [12:0] wr_fifo_usedw,
  input  logic        word_stb,
  output logic        grant_rd,
  output logic        grant_wr,
  output logic        sector_done,
  output logic        busy,
  output logic        stray_err,
  output logic [15:0] sector_cnt
);

  localparam int               CW         = $clog2(SECTOR_WORDS + 1);
  localparam logic [CW-1:0]    LAST_WORD  = CW'(SECTOR_WORDS - 1);
  localparam logic [CW-1:0]    FULL_WORDS = CW'(SECTOR_WORDS);
  localparam logic [3:0]       GUARD_LOAD = 4'(GUARD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GRANT_RD = 2'd1,
    GRANT_WR = 2'd2,
    GUARD    = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   word_cnt;
  logic [3:0]      guard_cnt;
  logic            last_owner;   // 1 = write channel held the last grant
  logic            armed;        // holds off grants for the first edge after reset
  logic            rd_ok;
  logic            wr_ok;
  logic            pick_rd;

  assign rd_ok   = rd_req && (rd_fifo_usedw < RD_HIGH_WATER);
  assign wr_ok   = wr_req && (32'(wr_fifo_usedw) >= 32'(SECTOR_WORDS));
  // On a tie the channel that did not own the last burst wins.
  assign pick_rd = rd_ok && (!wr_ok || last_owner);

  // Bus ownership FSM with burst word counter and guard down-counter.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state       <= IDLE;
      grant_rd    <= 1'b0;
      grant_wr    <= 1'b0;
      sector_done <= 1'b0;
      busy        <= 1'b0;
      sector_cnt  <= 16'd0;
      word_cnt    <= '0;
      guard_cnt   <= 4'd0;
      last_owner  <= 1'b1;
      armed       <= 1'b0;
    end else begin
      armed       <= 1'b1;
      sector_done <= 1'b0;
      case (state)
        IDLE: begin
          if (armed && pick_rd) begin
            state      <= GRANT_RD;
            grant_rd   <= 1'b1;
            busy       <= 1'b1;
            word_cnt   <= '0;
            last_owner <= 1'b0;
          end else if (armed && wr_ok) begin
            state      <= GRANT_WR;
            grant_wr   <= 1'b1;
            busy       <= 1'b1;
            word_cnt   <= '0;
            last_owner <= 1'b1;
          end
        end
        GRANT_RD, GRANT_WR: begin
          if (word_stb) begin
            if (word_cnt == LAST_WORD) begin
              state       <= GUARD;
              grant_rd    <= 1'b0;
              grant_wr    <= 1'b0;
              sector_done <= 1'b1;
              sector_cnt  <= sector_cnt + 16'd1;
              guard_cnt   <= GUARD_LOAD;
              word_cnt    <= FULL_WORDS;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        GUARD: begin
          if (guard_cnt == 4'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            guard_cnt <= guard_cnt - 4'd1;
          end
        end
        default: begin
          state    <= IDLE;
          grant_rd <= 1'b0;
          grant_wr <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Sticky flag for strobes arriving while neither channel owns the bus.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      stray_err <= 1'b0;
    end else if (word_stb && !grant_rd && !grant_wr) begin
      stray_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ide_fifo_arbiter.sv
// Bench for ide_fifo_arbiter (default parameters: 256 words, high water
// 3000, guard 3). The reference model tracks ownership as timestamps:
// which channel owns the bus, how many words it has moved, and the first
// clock edge at which a new grant may be registered.
module tb_ide_fifo_arbiter;

  logic        clk = 1'b0;
  logic        nRST = 1'b1;
  logic        rd_req = 1'b0;
  logic [12:0] rd_fifo_usedw = 13'd0;
  logic        wr_req = 1'b0;
  logic [12:0] wr_fifo_usedw = 13'd0;
  logic        word_stb = 1'b0;
  logic        grant_rd;
  logic        grant_wr;
  logic        sector_done;
  logic        busy;
  logic        stray_err;
  logic [15:0] sector_cnt;

  localparam int SW = 256;
  localparam int GC = 3;

  ide_fifo_arbiter dut (
    .clk           (clk),
    .nRST          (nRST),
    .rd_req        (rd_req),
    .rd_fifo_usedw (rd_fifo_usedw),
    .wr_req        (wr_req),
    .wr_fifo_usedw (wr_fifo_usedw),
    .word_stb      (word_stb),
    .grant_rd      (grant_rd),
    .grant_wr      (grant_wr),
    .sector_done   (sector_done),
    .busy          (busy),
    .stray_err     (stray_err),
    .sector_cnt    (sector_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: owner 0 = none, 1 = read, 2 = write
  int          n;
  int          ok_edge;
  int          m_owner;
  int          m_last;
  int          m_words;
  int          last_stb_edge;
  logic        m_done;
  logic        m_stray;
  logic [15:0] m_cnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    logic rdok, wrok, stb;
    rdok = rd_req && (rd_fifo_usedw < 13'd3000);
    wrok = wr_req && (wr_fifo_usedw >= 13'd256);
    stb  = word_stb;
    @(posedge clk);
    n++;
    m_done = 1'b0;
    if (m_owner == 0) begin
      if (stb) m_stray = 1'b1;
      if (n >= ok_edge && (rdok || wrok)) begin
        m_owner = (rdok && (!wrok || m_last == 2)) ? 1 : 2;
        m_last  = m_owner;
        m_words = 0;
      end
    end else if (stb) begin
      m_words++;
      if (m_words == SW) begin
        m_owner       = 0;
        m_done        = 1'b1;
        m_cnt         = m_cnt + 16'd1;
        ok_edge       = n + GC + 1;
        last_stb_edge = n;
      end
    end
    #1;
    chk("grant_rd",    16'(grant_rd),    16'(m_owner == 1));
    chk("grant_wr",    16'(grant_wr),    16'(m_owner == 2));
    chk("sector_done", 16'(sector_done), 16'(m_done));
    chk("busy",        16'(busy),        16'((m_owner != 0) || (n < ok_edge - 1)));
    chk("stray_err",   16'(stray_err),   16'(m_stray));
    chk("sector_cnt",  sector_cnt,       m_cnt);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    chk("rst_grant_rd",    16'(grant_rd),    16'd0);
    chk("rst_grant_wr",    16'(grant_wr),    16'd0);
    chk("rst_sector_done", 16'(sector_done), 16'd0);
    chk("rst_busy",        16'(busy),        16'd0);
    chk("rst_stray",       16'(stray_err),   16'd0);
    chk("rst_sector_cnt",  sector_cnt,       16'd0);
    m_owner = 0; m_last = 2; m_words = 0;
    m_done = 1'b0; m_stray = 1'b0; m_cnt = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST    = 1'b1;
    n       = 0;
    ok_edge = 2;
  endtask

  // Drives strobes (pct percent density) until the model sees the burst end.
  task automatic run_burst(input int pct);
    for (int i = 0; i < 4000 && m_owner != 0; i++) begin
      word_stb = ($urandom_range(0, 99) < pct);
      tick();
    end
    word_stb = 1'b0;
    chk("burst_ended", 16'(m_owner), 16'd0);
  endtask

  initial begin
    #2;
    do_reset();

    // read burst at a comfortable fill level; request dropped mid-burst
    rd_req = 1'b1; rd_fifo_usedw = 13'd100;
    tick();
    chk("no_grant_edge1", 16'(grant_rd), 16'd0);
    tick();
    chk("rd_grant_edge2", 16'(grant_rd), 16'd1);
    rd_req = 1'b0; rd_fifo_usedw = 13'd3500;
    run_burst(70);
    chk("rd_burst_cnt", sector_cnt, 16'd1);
    repeat (GC + 2) tick();
    chk("rd_busy_low", 16'(busy), 16'd0);

    // read high-water boundary
    rd_req = 1'b1; rd_fifo_usedw = 13'd3000;
    repeat (8) tick();
    chk("hw_3000_block", 16'(grant_rd), 16'd0);
    rd_fifo_usedw = 13'd2999;
    tick();
    chk("hw_2999_grant", 16'(grant_rd), 16'd1);
    rd_req = 1'b0;
    run_burst(100);
    repeat (GC + 2) tick();

    // write sector-size boundary
    wr_req = 1'b1; wr_fifo_usedw = 13'd255;
    repeat (6) tick();
    chk("wr_255_block", 16'(grant_wr), 16'd0);
    wr_fifo_usedw = 13'd256;
    tick();
    chk("wr_256_grant", 16'(grant_wr), 16'd1);
    wr_req = 1'b0;
    run_burst(50);

    // strobe during guard: sticky error, count unchanged
    word_stb = 1'b1;
    tick();
    word_stb = 1'b0;
    chk("guard_stray", 16'(stray_err), 16'd1);
    chk("guard_cnt",   sector_cnt,     16'd3);
    repeat (10) tick();
    chk("stray_sticky", 16'(stray_err), 16'd1);

    // reset in the middle of a read burst
    do_reset();
    rd_req = 1'b1; rd_fifo_usedw = 13'd100;
    repeat (2) tick();
    rd_req = 1'b0;
    word_stb = 1'b1;
    for (int i = 0; i < 200 && m_words < 100; i++) tick();
    word_stb = 1'b0;
    chk("mid_words", 16'(m_words), 16'd100);
    do_reset();
    repeat (6) tick();

    // both channels continuously ready: alternation and guard gap
    do_reset();
    rd_req = 1'b1; rd_fifo_usedw = 13'd10;
    wr_req = 1'b1; wr_fifo_usedw = 13'd1000;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 20 && !(grant_rd || grant_wr); i++) tick();
      chk("alt_granted", 16'(grant_rd || grant_wr), 16'd1);
      chk("alt_owner",   16'(grant_wr), 16'(b % 2));
      if (b > 0) chk("alt_gap", 16'(n - last_stb_edge), 16'(GC + 1));
      run_burst(100);
    end
    rd_req = 1'b0; wr_req = 1'b0;
    repeat (6) tick();

    // random traffic around both thresholds
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rd_req        = ($urandom_range(0, 3) != 0);
      wr_req        = ($urandom_range(0, 3) != 0);
      rd_fifo_usedw = ($urandom_range(0, 1) != 0) ? 13'(2998 + $urandom_range(0, 3))
                                                  : 13'($urandom_range(0, 8191));
      wr_fifo_usedw = ($urandom_range(0, 1) != 0) ? 13'(254 + $urandom_range(0, 3))
                                                  : 13'($urandom_range(0, 8191));
      word_stb      = ($urandom_range(0, 99) < 60);
      tick();
    end
    word_stb = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    repeat (4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
